// File: rtl/fetch_decode_stage_pkg.sv
// Shared RV32I op codes, NOP word and decode-bundle layout for the front end.
// Used by fetch_decode_stage, its immediate generator and the pipeline controller.
package fetch_decode_stage_pkg;

    localparam logic [4:0] R_TYPE = 5'b01100;
    localparam logic [4:0] IMME   = 5'b00100;
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] NOP    = IMME;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Field order MSB->LSB gives f7 at [23] down to op at [4:0].
    typedef struct packed {
        logic       f7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [4:0] op;
    } dec_t;

    localparam dec_t NOP_BUNDLE = '{f7: 1'b0, rs2: 5'd0, rs1: 5'd0, f3: 3'd0, rd: 5'd0, op: NOP};

    function automatic logic is_rv32i_op(input logic [4:0] op);
        return (op == R_TYPE) || (op == IMME) || (op == LOAD) || (op == STORE) ||
               (op == BRANCH) || (op == JAL) || (op == JALR) || (op == LUI) ||
               (op == AUIPC);
    endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Front-end bus: controller/E-stage inputs, instruction memory, decode outputs.
// master = fetch_decode_stage, slave = surrounding pipeline and memory.
interface fetch_decode_stage_if;
    logic        stall;
    logic        next_pc_sel;
    logic [31:0] jb_pc;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic [31:0] D_pc;
    logic [23:0] D_out;
    logic [31:0] D_imm;
    logic        illegal;
    logic [31:0] illegal_pc;

    modport master (
        input  stall, next_pc_sel, jb_pc, im_inst,
        output im_addr, D_pc, D_out, D_imm, illegal, illegal_pc
    );

    modport slave (
        output stall, next_pc_sel, jb_pc, im_inst,
        input  im_addr, D_pc, D_out, D_imm, illegal, illegal_pc
    );
endinterface

// File: rtl/fetch_decode_stage_imm_gen.sv
// Immediate generator: op + instruction word -> sign-extended 32-bit immediate.
// Purely combinational, no backpressure.
module imm_gen
    import fetch_decode_stage_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:7] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (op)
            IMME, LOAD, JALR: imm = {{20{inst[31]}}, inst[31:20]};
            STORE:            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            BRANCH:           imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            LUI, AUIPC:       imm = {inst[31:12], 12'b0};
            JAL:              imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:          imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// PC + IF/ID register + decode; optional sticky illegal-op trap under ILLEGAL_OP_TRAP_EN.
// Latency: fetched word reaches D_out/D_imm one cycle after im_addr presents it.
// Backpressure: stall holds PC and IF/ID; redirect (next_pc_sel=0) overrides stall.
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_decode_stage_if.master  bus
);

    logic [31:0] F_pc;
    logic [31:0] D_inst;
    logic [31:0] D_pc;
    dec_t        raw_dec;
    logic [31:0] raw_imm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            F_pc   <= RESET_PC;
            D_inst <= NOP_INST;
            D_pc   <= '0;
        end else if (!bus.next_pc_sel) begin
            F_pc   <= {bus.jb_pc[31:1], 1'b0};
            D_inst <= NOP_INST;
            D_pc   <= '0;
        end else if (!bus.stall) begin
            F_pc   <= F_pc + 32'd4;
            D_inst <= bus.im_inst;
            D_pc   <= F_pc;
        end
    end

    always_comb begin
        raw_dec     = NOP_BUNDLE;
        raw_dec.op  = D_inst[6:2];
        raw_dec.rd  = D_inst[11:7];
        raw_dec.f3  = D_inst[14:12];
        raw_dec.rs1 = D_inst[19:15];
        raw_dec.rs2 = D_inst[24:20];
        raw_dec.f7  = D_inst[30];
    end

    imm_gen u_imm_gen (
        .op   (raw_dec.op),
        .inst (D_inst[31:7]),
        .imm  (raw_imm)
    );

    assign bus.im_addr = F_pc;
    assign bus.D_pc    = D_pc;

`ifdef ILLEGAL_OP_TRAP_EN
    logic        bad_inst;
    logic        illegal_q;
    logic [31:0] illegal_pc_q;

    assign bad_inst = (D_inst[1:0] != 2'b11) || !is_rv32i_op(raw_dec.op);

    // Only an instruction that actually advances out of IF/ID can trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else if (!illegal_q && bus.next_pc_sel && !bus.stall && bad_inst) begin
            illegal_q    <= 1'b1;
            illegal_pc_q <= D_pc;
        end
    end

    assign bus.D_out      = bad_inst ? NOP_BUNDLE : raw_dec;
    assign bus.D_imm      = bad_inst ? 32'd0 : raw_imm;
    assign bus.illegal    = illegal_q;
    assign bus.illegal_pc = illegal_pc_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^D_inst[1:0];

    assign bus.D_out      = raw_dec;
    assign bus.D_imm      = raw_imm;
    assign bus.illegal    = 1'b0;
    assign bus.illegal_pc = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: directed test-plan cases plus random stall/redirect traffic.
module tb_fetch_decode_stage;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h100;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_decode_stage_if bus ();

    fetch_decode_stage #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [31:0] imem [0:255];
    assign bus.im_inst = imem[bus.im_addr[9:2]];

    typedef struct {
        logic [31:0] im_addr;
        logic [31:0] d_pc;
        logic [31:0] d_out;
        logic [31:0] d_imm;
        logic [31:0] ill;
        logic [31:0] ill_pc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_fpc, m_dinst, m_dpc, m_illpc;
    logic        m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] i);
        case (i[6:2])
            5'h0C, 5'h04, 5'h00, 5'h08, 5'h18, 5'h1B, 5'h19, 5'h0D, 5'h05: return i[1:0] == 2'b11;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_out(input logic [31:0] i);
        if (TRAP && !legal(i)) return 32'h4;
        return {8'h0, i[30], i[24:20], i[19:15], i[14:12], i[11:7], i[6:2]};
    endfunction

    // Immediates built from an all-sign word plus shifted field pieces.
    function automatic logic [31:0] exp_imm(input logic [31:0] i);
        logic [31:0] sx;
        sx = {32{i[31]}};
        if (TRAP && !legal(i)) return 32'h0;
        case (i[6:2])
            5'h04, 5'h00, 5'h19: return (sx << 12) | {20'h0, i[31:20]};
            5'h08:               return (sx << 12) | {20'h0, i[31:25], i[11:7]};
            5'h18:               return (sx << 12) | ({31'h0, i[7]} << 11) | ({26'h0, i[30:25]} << 5) | ({28'h0, i[11:8]} << 1);
            5'h0D, 5'h05:        return i & 32'hFFFF_F000;
            5'h1B:               return (sx << 20) | ({24'h0, i[19:12]} << 12) | ({31'h0, i[20]} << 11) | ({22'h0, i[30:21]} << 1);
            default:             return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_fpc = RPC; m_dinst = NOPW; m_dpc = 0; m_ill = 0; m_illpc = 0;
    endtask

    task automatic model_edge(input logic s, input logic sel, input logic [31:0] jb);
        exp_t e;
        if (TRAP && !m_ill && sel && !s && !legal(m_dinst)) begin
            m_ill = 1'b1;
            m_illpc = m_dpc;
        end
        if (!sel) begin
            m_fpc = jb & 32'hFFFF_FFFE; m_dinst = NOPW; m_dpc = 0;
        end else if (!s) begin
            m_dinst = imem[m_fpc[9:2]]; m_dpc = m_fpc; m_fpc = m_fpc + 32'd4;
        end
        e.im_addr = m_fpc;
        e.d_pc    = m_dpc;
        e.d_out   = exp_out(m_dinst);
        e.d_imm   = exp_imm(m_dinst);
        e.ill     = {31'h0, m_ill};
        e.ill_pc  = m_illpc;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic s, input logic sel, input logic [31:0] jb);
        bus.stall = s; bus.next_pc_sel = sel; bus.jb_pc = jb;
        model_edge(s, sel, jb);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_im_addr", bus.im_addr, e.im_addr);
                chk("sb_d_pc", bus.D_pc, e.d_pc);
                chk("sb_d_out", {8'h0, bus.D_out}, e.d_out);
                chk("sb_d_imm", bus.D_imm, e.d_imm);
                chk("sb_illegal", {31'h0, bus.illegal}, e.ill);
                chk("sb_illegal_pc", bus.illegal_pc, e.ill_pc);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin : driver
        logic [4:0]  ops [0:8];
        logic [31:0] r;
        ops = '{5'h0C, 5'h04, 5'h00, 5'h08, 5'h18, 5'h1B, 5'h19, 5'h0D, 5'h05};
        for (int k = 0; k < 256; k++) begin
            r = $urandom();
            imem[k] = {r[31:7], ops[$urandom_range(0, 8)], 2'b11};
            if (k >= 200 && k <= 250 && $urandom_range(0, 3) == 0) imem[k] = $urandom();
        end
        imem[64] = 32'hFFC1_2083;
        imem[65] = 32'hFE00_0EE3;
        imem[66] = 32'h0080_00EF;
        imem[67] = 32'h1234_50B7;
        imem[2]  = 32'hFFFF_FFFF;

        bus.stall = 1'b0; bus.next_pc_sel = 1'b1; bus.jb_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_im_addr", bus.im_addr, 32'h100);
        chk("rst_d_out", {8'h0, bus.D_out}, 32'h4);
        chk("rst_d_pc", bus.D_pc, 32'h0);
        chk("rst_illegal", {31'h0, bus.illegal}, 32'h0);
        rst = 1'b1;

        step(0, 1, 0);
        chk("lw_op", {27'h0, bus.D_out[4:0]}, 32'h0);
        chk("lw_rd", {27'h0, bus.D_out[9:5]}, 32'h1);
        chk("lw_f3", {29'h0, bus.D_out[12:10]}, 32'h2);
        chk("lw_rs1", {27'h0, bus.D_out[17:13]}, 32'h2);
        chk("lw_imm", bus.D_imm, 32'hFFFF_FFFC);
        chk("lw_d_pc", bus.D_pc, 32'h100);
        step(0, 1, 0);
        chk("btype_imm", bus.D_imm, 32'hFFFF_FFFC);
        chk("two_edges_d_pc", bus.D_pc, 32'h104);
        step(0, 1, 0);
        chk("jtype_imm", bus.D_imm, 32'h8);
        step(0, 1, 0);
        chk("lui_imm", bus.D_imm, 32'h1234_5000);

        step(0, 0, 32'h1C);
        step(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0);
            chk("stall_im_addr", bus.im_addr, 32'h20);
            chk("stall_d_pc", bus.D_pc, 32'h1C);
        end
        step(0, 1, 0);
        chk("unstall_d_pc", bus.D_pc, 32'h20);

        step(1, 0, 32'h41);
        chk("redir_im_addr", bus.im_addr, 32'h40);
        chk("redir_d_out", {8'h0, bus.D_out}, 32'h4);

`ifdef ILLEGAL_OP_TRAP_EN
        step(0, 0, 32'h8);
        step(0, 1, 0);
        chk("ill_nop_out", {8'h0, bus.D_out}, 32'h4);
        chk("ill_imm", bus.D_imm, 32'h0);
        step(0, 1, 0);
        chk("ill_flag", {31'h0, bus.illegal}, 32'h1);
        chk("ill_pc", bus.illegal_pc, 32'h8);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("ill_flag_hold", {31'h0, bus.illegal}, 32'h1);
        chk("ill_pc_hold", bus.illegal_pc, 32'h8);
`endif

        step(0, 0, 32'hFFFF_FFFD);
        step(0, 1, 0);
        chk("wrap_im_addr", bus.im_addr, 32'h0);
        chk("wrap_d_pc", bus.D_pc, 32'hFFFF_FFFC);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1023));
        end

        rst = 1'b0;
        #1;
        model_reset();
        chk("rst2_im_addr", bus.im_addr, 32'h100);
        chk("rst2_d_out", {8'h0, bus.D_out}, 32'h4);
        chk("rst2_d_pc", bus.D_pc, 32'h0);
        chk("rst2_illegal", {31'h0, bus.illegal}, 32'h0);
        chk("rst2_illegal_pc", bus.illegal_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0);
        chk("rst2_first_fetch", bus.D_pc, 32'h100);
        step(0, 1, 0);
        chk("rst2_second_fetch", bus.D_pc, 32'h104);

        @(posedge clk);
        #5;
        chk("sb_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
